// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one memory bus.
// Define MEM_ARBITER_TIMEOUT_EN to add a watchdog that aborts a stalled transaction.
module mem_arbiter #(
    parameter int DATA_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_read,
    input  logic [15:0] i_address,
    output logic        i_resp,
    output logic [15:0] i_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    input  logic [1:0]  d_byte_enable,
    output logic        d_resp,
    output logic [15:0] d_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_byte_enable,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic        timeout_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0] state_q, state_d;
    logic       d_req;
    logic       timeout;

    assign d_req = d_read | d_write;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be within 1..255");
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wdog_q, wdog_d;
    logic       serving;

    // Counter holds the number of completed stall cycles, so the abort lands on the limit-th cycle.
    assign serving     = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign timeout     = serving && !mem_resp && (wdog_q == WDOG_LIMIT);
    assign timeout_err = timeout;
    assign wdog_d      = (serving && !mem_resp && !timeout) ? wdog_q + 8'd1 : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= 8'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req && i_read) begin
                    state_d = (DATA_PRIORITY != 0) ? SERVE_D : SERVE_I;
                end else if (d_req) begin
                    state_d = SERVE_D;
                end else if (i_read) begin
                    state_d = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes track the owner's live request, so a dropped request also drops the strobe.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 16'h0000;
        mem_wdata       = 16'h0000;
        mem_byte_enable = 2'b00;
        i_resp          = 1'b0;
        d_resp          = 1'b0;
        case (state_q)
            SERVE_I: begin
                mem_read        = i_read;
                mem_address     = i_address;
                mem_byte_enable = 2'b11;
                i_resp          = mem_resp | timeout;
            end
            SERVE_D: begin
                mem_read        = d_read;
                mem_write       = d_write;
                mem_address     = d_address;
                mem_wdata       = d_wdata;
                mem_byte_enable = d_byte_enable;
                d_resp          = mem_resp | timeout;
            end
            default: ;
        endcase
    end

    assign i_rdata = timeout ? 16'h0000 : mem_rdata;
    assign d_rdata = timeout ? 16'h0000 : mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: two instances (data priority and fetch priority) driven
// by directed requests, with a latency-programmable memory model behind each.
module tb_mem_arbiter;

    typedef struct {
        bit          isD;
        bit          isWrite;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
        bit          timedOut;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       iRead = '0;
    logic [1:0]       dRead = '0;
    logic [1:0]       dWrite = '0;
    logic [1:0][15:0] iAddress = '0;
    logic [1:0][15:0] dAddress = '0;
    logic [1:0][15:0] dWdata = '0;
    logic [1:0][1:0]  dByteEnable = '0;
    logic [1:0]       iResp, dResp, memRead, memWrite, memResp, timeoutErr;
    logic [1:0][15:0] iRdata, dRdata, memAddress, memWdata, memRdata;
    logic [1:0][1:0]  memByteEnable;

    bit   respEnable = 1'b1;
    bit   forceResp  = 1'b0;
    int   respDelay  = 3;
    int   waitCnt [2];
    int   vectors     = 0;
    int   miscompares = 0;
    exp_t expQ0[$];
    exp_t expQ1[$];
    bit [1:0] gapPending = '0;

    always #5 clk = ~clk;

    // Instance 0 favours the data port, instance 1 favours the fetch port.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .DATA_PRIORITY (g == 0 ? 1 : 0),
            .TIMEOUT_CYCLES(4)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_read         (iRead[g]),
            .i_address      (iAddress[g]),
            .i_resp         (iResp[g]),
            .i_rdata        (iRdata[g]),
            .d_read         (dRead[g]),
            .d_write        (dWrite[g]),
            .d_address      (dAddress[g]),
            .d_wdata        (dWdata[g]),
            .d_byte_enable  (dByteEnable[g]),
            .d_resp         (dResp[g]),
            .d_rdata        (dRdata[g]),
            .mem_read       (memRead[g]),
            .mem_write      (memWrite[g]),
            .mem_address    (memAddress[g]),
            .mem_wdata      (memWdata[g]),
            .mem_byte_enable(memByteEnable[g]),
            .mem_resp       (memResp[g]),
            .mem_rdata      (memRdata[g]),
            .timeout_err    (timeoutErr[g])
        );
    end

    // Memory returns address ^ 16'h1274 and answers once a strobe has waited respDelay cycles.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            memRdata[g] = memAddress[g] ^ 16'h1274;
            memResp[g]  = forceResp ||
                          (respEnable && (memRead[g] || memWrite[g]) && waitCnt[g] >= respDelay);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n || !(memRead[g] || memWrite[g]) || memResp[g]) begin
                waitCnt[g] <= 0;
            end else begin
                waitCnt[g] <= waitCnt[g] + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pushExp(input int g, input bit isD, input bit isWrite, input logic [15:0] addr,
                           input logic [15:0] data, input logic [1:0] be, input bit timedOut);
        exp_t e;
        e.isD = isD; e.isWrite = isWrite; e.addr = addr;
        e.data = data; e.be = be; e.timedOut = timedOut;
        if (g == 0) expQ0.push_back(e);
        else        expQ1.push_back(e);
    endtask

    task automatic waitResp(input int g, input bit isD);
        bit seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            seen = isD ? dResp[g] : iResp[g];
        end
        checkOutput($sformatf("respArrived%0d", g), {31'd0, seen}, 1);
        if (seen) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulusFetch(input int g, input logic [15:0] addr);
        iAddress[g] = addr;
        iRead[g]    = 1'b1;
        waitResp(g, 1'b0);
        iRead[g]    = 1'b0;
    endtask

    task automatic applyStimulusData(input int g, input bit isWrite, input logic [15:0] addr,
                                     input logic [15:0] wdata, input logic [1:0] be);
        dAddress[g]    = addr;
        dWdata[g]      = wdata;
        dByteEnable[g] = be;
        dWrite[g]      = isWrite;
        dRead[g]       = !isWrite;
        waitResp(g, 1'b1);
        dWrite[g]      = 1'b0;
        dRead[g]       = 1'b0;
    endtask

    // Monitor: every response is matched against the oldest expectation for that instance,
    // and the cycle after a response must carry no memory strobes.
    initial begin : monitor
        exp_t e;
        bit   have;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (gapPending[g]) begin
                    checkOutput($sformatf("idleGap%0d", g), {30'd0, memRead[g], memWrite[g]}, 0);
                    gapPending[g] = 1'b0;
                end
                if (rst_n && (iResp[g] || dResp[g])) begin
                    gapPending[g] = 1'b1;
                    have = 1'b0;
                    if (g == 0 && expQ0.size() > 0) begin
                        e = expQ0.pop_front();
                        have = 1'b1;
                    end else if (g == 1 && expQ1.size() > 0) begin
                        e = expQ1.pop_front();
                        have = 1'b1;
                    end
                    if (!have) begin
                        checkOutput($sformatf("unexpectedResp%0d", g), {30'd0, iResp[g], dResp[g]}, 0);
                    end else begin
                        checkOutput("respPort", {30'd0, iResp[g], dResp[g]}, e.isD ? 2'b01 : 2'b10);
                        checkOutput("timeoutErr", {31'd0, timeoutErr[g]}, {31'd0, e.timedOut});
                        checkOutput("memAddress", {16'd0, memAddress[g]}, {16'd0, e.addr});
                        checkOutput("memByteEnable", {30'd0, memByteEnable[g]}, {30'd0, e.be});
                        if (e.isWrite) begin
                            checkOutput("memWriteStrobe", {30'd0, memRead[g], memWrite[g]}, 2'b01);
                            checkOutput("memWdata", {16'd0, memWdata[g]}, {16'd0, e.data});
                        end else begin
                            checkOutput("memReadStrobe", {30'd0, memRead[g], memWrite[g]}, 2'b10);
                            checkOutput("rdata", {16'd0, e.isD ? dRdata[g] : iRdata[g]}, {16'd0, e.data});
                            if (!e.isD) checkOutput("fetchWdata", {16'd0, memWdata[g]}, 0);
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("resetOutputs", {22'd0, memRead, memWrite, iResp, dResp, timeoutErr}, 0);
        rst_n = 1'b1;

        // Single fetch: strobe one cycle after the request, data 16'h0040 ^ 16'h1274.
        @(negedge clk);
        pushExp(0, 1'b0, 1'b0, 16'h0040, 16'h1234, 2'b11, 1'b0);
        fork
            applyStimulusFetch(0, 16'h0040);
            begin
                #1 checkOutput("latencyIdle", {31'd0, memRead[0]}, 0);
                @(posedge clk);
                #1 checkOutput("latencyStrobe", {31'd0, memRead[0]}, 1);
            end
        join

        // A memory response while idle must not produce a port response.
        @(negedge clk);
        forceResp = 1'b1;
        #1 checkOutput("idleRespIgnored", {28'd0, iResp, dResp}, 0);
        @(negedge clk);
        forceResp = 1'b0;

        // Simultaneous fetch and write: priority decides the order on each instance.
        @(negedge clk);
        pushExp(0, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 2'b01, 1'b0);
        pushExp(0, 1'b0, 1'b0, 16'h0200, 16'h1074, 2'b11, 1'b0);
        pushExp(1, 1'b0, 1'b0, 16'h0200, 16'h1074, 2'b11, 1'b0);
        pushExp(1, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 2'b01, 1'b0);
        fork
            applyStimulusFetch(0, 16'h0200);
            applyStimulusData(0, 1'b1, 16'h0100, 16'hBEEF, 2'b01);
            applyStimulusFetch(1, 16'h0200);
            applyStimulusData(1, 1'b1, 16'h0100, 16'hBEEF, 2'b01);
        join

        // Zero-latency memory: response in the first serve cycle.
        @(negedge clk);
        respDelay = 0;
        pushExp(0, 1'b0, 1'b0, 16'h00FE, 16'h128A, 2'b11, 1'b0);
        pushExp(1, 1'b1, 1'b0, 16'h8001, 16'h9275, 2'b10, 1'b0);
        fork
            applyStimulusFetch(0, 16'h00FE);
            applyStimulusData(1, 1'b0, 16'h8001, 16'h0000, 2'b10);
        join
        @(negedge clk);
        respDelay = 3;

        // Reset two cycles into a write: strobes drop at once, then the held write is re-served.
        respEnable = 1'b0;
        @(negedge clk);
        pushExp(0, 1'b1, 1'b1, 16'h0300, 16'h5A5A, 2'b11, 1'b0);
        fork
            applyStimulusData(0, 1'b1, 16'h0300, 16'h5A5A, 2'b11);
            begin
                @(posedge clk);
                @(posedge clk);
                #3 checkOutput("serveDStrobe", {31'd0, memWrite[0]}, 1);
                rst_n = 1'b0;
                #1 checkOutput("resetDropStrobe", {30'd0, memRead[0], memWrite[0]}, 0);
                checkOutput("resetNoResp", {28'd0, iResp, dResp}, 0);
                repeat (2) @(negedge clk);
                checkOutput("resetHeldLow", {30'd0, memWrite[0], dResp[0]}, 0);
                rst_n = 1'b1;
                @(posedge clk);
                #1 respEnable = 1'b1;
            end
        join

`ifdef MEM_ARBITER_TIMEOUT_EN
        // Stalled read aborts on the fourth serve cycle with zero data.
        respEnable = 1'b0;
        @(negedge clk);
        pushExp(0, 1'b1, 1'b0, 16'h0400, 16'h0000, 2'b11, 1'b1);
        fork
            applyStimulusData(0, 1'b0, 16'h0400, 16'h0000, 2'b11);
            begin
                repeat (3) @(negedge clk);
                checkOutput("noEarlyTimeout", {30'd0, timeoutErr[0], dResp[0]}, 0);
            end
        join
        respEnable = 1'b1;
`else
        // Without the watchdog a stalled read waits indefinitely and then completes normally.
        respEnable = 1'b0;
        @(negedge clk);
        pushExp(0, 1'b1, 1'b0, 16'h0400, 16'h1674, 2'b11, 1'b0);
        fork
            applyStimulusData(0, 1'b0, 16'h0400, 16'h0000, 2'b11);
            begin
                repeat (300) @(negedge clk);
                checkOutput("stallNoTimeout", {29'd0, dResp[0], timeoutErr[0], memRead[0]}, 3'b001);
                @(posedge clk);
                #1 respEnable = 1'b1;
            end
        join
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained0", expQ0.size(), 0);
        checkOutput("scoreboardDrained1", expQ1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_PRIORITY, default 1, 1 = data port wins simultaneous requests, 0 = instruction port wins.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, range 1-255, watchdog limit in cycles (used only with MEM_ARBITER_TIMEOUT_EN).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_read  in  1  instruction-fetch read request, held until i_resp.
REQ-006 i_address  in  16  instruction-fetch byte address.
REQ-007 i_resp  out  1  instruction-fetch completion pulse.
REQ-008 i_rdata  out  16  instruction-fetch read data.
REQ-009 d_read, d_write  in  1 each  data-port read/write request, held until d_resp, never both high.
REQ-010 d_address  in  16  data-port byte address.
REQ-011 d_wdata  in  16  data-port write data.
REQ-012 d_byte_enable  in  2  data-port write mask.
REQ-013 d_resp  out  1  data-port completion pulse.
REQ-014 d_rdata  out  16  data-port read data.
REQ-015 mem_read, mem_write  out  1 each  shared memory strobes.
REQ-016 mem_address, mem_wdata  out  16 each  shared memory address/write data.
REQ-017 mem_byte_enable  out  2  shared memory mask.
REQ-018 mem_resp  in  1  memory completion.
REQ-019 mem_rdata  in  16  memory read data.
REQ-020 timeout_err  out  1  watchdog abort pulse (tied 0 without macro).

Function
REQ-021 FSM states IDLE, SERVE_I, SERVE_D; state is registered.
REQ-022 IDLE: no mem strobes; i_resp = d_resp = 0.
REQ-023 IDLE, only data request -> SERVE_D; only i_read -> SERVE_I; both -> per DATA_PRIORITY; none -> IDLE.
REQ-024 SERVE_I: mem_read = i_read, mem_write = 0, mem_address = i_address, mem_byte_enable = 2'b11, mem_wdata = 0.
REQ-025 SERVE_D: mem_read = d_read, mem_write = d_write, mem_address = d_address, mem_wdata = d_wdata, mem_byte_enable = d_byte_enable.
REQ-026 Owner resp = mem_resp combinationally; non-owner resp = 0 always.
REQ-027 i_rdata = d_rdata = mem_rdata combinationally; valid only with own resp.
REQ-028 Owner state with mem_resp = 1 -> IDLE next cycle; always one IDLE cycle between grants.
REQ-029 Latency: request seen in IDLE at cycle N -> mem strobe at N+1; resp same cycle as mem_resp.
REQ-030 Owner deasserts request while serving (protocol violation): strobes follow request low, FSM stays in owner state until mem_resp or timeout.
REQ-031 Loser keeps request; served next arbitration after the IDLE cycle; no request dropped.
REQ-032 mem_resp in IDLE ignored, no resp generated.

Reset
REQ-033 rst_n low: state = IDLE immediately, watchdog = 0; all strobes, resps and timeout_err = 0 regardless of clk.
REQ-034 Reset mid-transaction aborts it silently; no resp issued; arbitration restarts on first rising edge after rst_n high.

Configuration
REQ-035 Macro MEM_ARBITER_TIMEOUT_EN defined: 8-bit watchdog counts cycles in SERVE_I/SERVE_D without mem_resp; cleared on entry to IDLE.
REQ-036 Count reaching TIMEOUT_CYCLES: one-cycle owner resp with owner rdata forced 16'h0000, timeout_err = 1 same cycle, next state IDLE.
REQ-037 mem_resp coincident with timeout: normal completion, timeout_err = 0.
REQ-038 Macro undefined: no counter, timeout_err tied 0, owner state waits indefinitely.

Verification
REQ-039 Reset release, i_read=1 addr 16'h0040, mem_resp after 3 cycles with rdata 16'h1234 -> mem_read high cycle 1, i_resp pulse with i_rdata 16'h1234, d_resp 0.
REQ-040 i_read and d_write (addr 16'h0100, wdata 16'hBEEF, mask 2'b01) same cycle, DATA_PRIORITY=1 -> write served first, one IDLE cycle, then fetch served.
REQ-041 Same stimulus, DATA_PRIORITY=0 -> fetch first, then write; mem_byte_enable 2'b11 then 2'b01.
REQ-042 rst_n low two cycles into SERVE_D -> strobes drop immediately, no d_resp, FSM re-arbitrates after release.
REQ-043 MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_resp held 0 -> d_resp and timeout_err pulse together, d_rdata 16'h0000, then IDLE.
